// File: rtl/timer_arbiter_if.sv
// Bundle between the requesters/timer and the countdown arbiter.
// The arbiter side uses the slave modport.
interface timer_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic            tick;
    logic [N-1:0]    req;
    logic [N*DW-1:0] delay;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [DW-1:0]   remaining;

    modport master (
        output tick, req, delay,
        input  grant, done, busy, remaining
    );

    modport slave (
        input  tick, req, delay,
        output grant, done, busy, remaining
    );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting one shared tick-driven countdown to N requesters.
// Outputs are Moore-decoded from the registered state and owner index.
module timer_arbiter #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input logic            clk,
    input logic            rst,
    timer_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [DW-1:0] count, count_nxt;
    logic [IW-1:0] winner;
    logic          found;
    logic [DW-1:0] sel_delay;

    // Search upward from ptr+1 with wrap; ptr holds the last owner, so it ranks last.
    always_comb begin
        int            sum;
        logic [IW-1:0] idx;
        winner = '0;
        found  = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) sum = sum - N;
            idx = IW'(sum);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign sel_delay = bus.delay[int'(winner)*DW +: DW];

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        count_nxt = count;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt = winner;
                    count_nxt = sel_delay;
                    state_nxt = (sel_delay == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort has priority over a coinciding final tick.
                if (!bus.req[owner]) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                    ptr_nxt   = owner;
                end else if (bus.tick && count != '0) begin
                    count_nxt = count - 1'b1;
                    if (count == DW'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                count_nxt = '0;
                ptr_nxt   = owner;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= '0;
            count <= '0;
            ptr   <= IW'(N - 1);
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            count <= count_nxt;
            ptr   <= ptr_nxt;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign bus.grant[i] = (state != IDLE) && (owner == IW'(i));
        assign bus.done[i]  = (state == DONE) && (owner == IW'(i));
    end

    assign bus.busy      = (state != IDLE);
    assign bus.remaining = (state == RUN) ? count : '0;
endmodule
